// File: rtl/seq_detect_stream_ctrl.sv
// seq_detect_stream_ctrl: takes parallel words on a valid/ready input, feeds them MSB-first
// into an external 0110 non-overlapping detector, and counts the detector hits for each word.
// Latency: DATA_W+2 cycles from acceptance to out_valid (DATA_W+3 with SEQ_CTRL_WORD_ISOLATE_EN).
// Backpressure: in_ready is high only in IDLE. A result stays in REPORT until out_ready is seen.
//
// Optional build macro: SEQ_CTRL_WORD_ISOLATE_EN. When it is defined, a one-cycle CLEAR state
// pulses det_clear before each word, so every word is scanned from a clean detector.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset
//   in_valid/in_ready input word handshake; in_data[DATA_W-1] is applied first
//   det_en, det_bit   advance strobe and data bit to the detector (en / data_in)
//   det_clear         one-cycle detector clear, ORed with reset at the top level
//   det_detected      registered detected flag from the detector
//   out_valid/out_ready, out_matches   per-word result handshake and match count
//   total_matches     saturating count of every match since reset
//   busy              high whenever the controller is not in IDLE
module seq_detect_stream_ctrl #(
    parameter  int DATA_W  = 8,
    parameter  int TOTAL_W = 16,
    localparam int MATCH_W = $clog2(DATA_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               det_en,
    output logic               det_bit,
    output logic               det_clear,
    input  logic               det_detected,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MATCH_W-1:0] out_matches,
    output logic [TOTAL_W-1:0] total_matches,
    output logic               busy
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
`ifdef SEQ_CTRL_WORD_ISOLATE_EN
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_ENTRY  = ST_CLEAR;
`else
    localparam logic [2:0] ST_ENTRY  = ST_SHIFT;
`endif

    logic [2:0]         state_q,       state_d;
    logic [DATA_W-1:0]  shreg_q,       shreg_d;
    logic [CNT_W-1:0]   bitcnt_q,      bitcnt_d;
    logic               sample_q,      sample_d;
    logic [MATCH_W-1:0] match_cnt_q,   match_cnt_d;
    logic [MATCH_W-1:0] out_matches_q, out_matches_d;
    logic [TOTAL_W-1:0] total_q,       total_d;
    logic               sample_hit;

    // Control outputs decode straight from the state so that the first SHIFT
    // cycle strobes the detector in the cycle right after acceptance.
    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign det_en        = (state_q == ST_SHIFT);
    assign det_bit       = det_en & shreg_q[DATA_W-1];
    assign out_valid     = (state_q == ST_REPORT);
    assign out_matches   = out_matches_q;
    assign total_matches = total_q;
`ifdef SEQ_CTRL_WORD_ISOLATE_EN
    assign det_clear     = (state_q == ST_CLEAR);
`else
    assign det_clear     = 1'b0;
`endif

    // The detector registers its flag on the det_en edge. The result of a bit therefore
    // appears one cycle later, and sample_q marks exactly those cycles. A detected
    // level held over from an earlier word never lines up with sample_q, because
    // the cycle before the first SHIFT cycle always has det_en low.
    assign sample_hit = sample_q & det_detected;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        match_cnt_d   = match_cnt_q;
        out_matches_d = out_matches_q;
        sample_d      = det_en;

        if (sample_hit) begin
            match_cnt_d = match_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d     = in_data;
                    bitcnt_d    = '0;
                    match_cnt_d = '0;
                    state_d     = ST_ENTRY;
                end
            end
`ifdef SEQ_CTRL_WORD_ISOLATE_EN
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
`endif
            ST_SHIFT: begin
                shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final bit's sample lands in this cycle, so capture the
                // count including it.
                out_matches_d = match_cnt_d;
                state_d       = ST_REPORT;
            end
            ST_REPORT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The running total stops at its maximum value and never wraps.
    always_comb begin
        total_d = total_q;
        if (sample_hit && (total_q != TOTAL_MAX)) begin
            total_d = total_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            sample_q      <= 1'b0;
            match_cnt_q   <= '0;
            out_matches_q <= '0;
            total_q       <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            sample_q      <= sample_d;
            match_cnt_q   <= match_cnt_d;
            out_matches_q <= out_matches_d;
            total_q       <= total_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// tb_seq_detect_stream_ctrl: drives the stream controller together with a behavioural 0110
// detector, checks per-word results, timing and handshakes, and runs a second instance
// with a 2-bit total to observe saturation.
module tb_seq_detect_stream_ctrl;
`ifdef SEQ_CTRL_WORD_ISOLATE_EN
    localparam int ISO = 1;
`else
    localparam int ISO = 0;
`endif
    localparam int DW  = 8;
    localparam int LAT = DW + 2 + ISO;

    logic       clk = 1'b0;
    logic       reset, in_valid, out_ready, sat_en;
    logic [7:0] in_data;

    logic        in_ready, det_en, det_bit, det_clear, det_detected, out_valid, busy;
    logic [3:0]  out_matches;
    logic [15:0] total_matches;

    logic       s_in_ready, s_det_en, s_det_bit, s_det_clear, s_det_detected, s_out_valid, s_busy;
    logic [3:0] s_out_matches;
    logic [1:0] s_total;
    logic       sat_reset;

    assign sat_reset = reset | ~sat_en;

    always #5 clk = ~clk;

    seq_detect_stream_ctrl #(.DATA_W(DW), .TOTAL_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .det_en(det_en), .det_bit(det_bit), .det_clear(det_clear), .det_detected(det_detected),
        .out_valid(out_valid), .out_ready(out_ready), .out_matches(out_matches),
        .total_matches(total_matches), .busy(busy));

    seq_detect_stream_ctrl #(.DATA_W(DW), .TOTAL_W(2)) u_sat (
        .clk(clk), .reset(sat_reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .det_en(s_det_en), .det_bit(s_det_bit), .det_clear(s_det_clear), .det_detected(s_det_detected),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_matches(s_out_matches),
        .total_matches(s_total), .busy(s_busy));

    // Behavioural 0110 non-overlapping detector. The flag is registered on en and
    // holds its value while en is low.
    function automatic int det_next(input int s, input logic b);
        case (s)
            0:       return b ? 0 : 1;
            1:       return b ? 2 : 1;
            2:       return b ? 3 : 1;
            default: return 0;
        endcase
    endfunction

    int d_st, s_st;
    always @(posedge clk) begin
        if (reset || det_clear) begin
            d_st <= 0; det_detected <= 1'b0;
        end else if (det_en) begin
            det_detected <= (d_st == 3) && !det_bit;
            d_st <= det_next(d_st, det_bit);
        end
    end
    always @(posedge clk) begin
        if (sat_reset || s_det_clear) begin
            s_st <= 0; s_det_detected <= 1'b0;
        end else if (s_det_en) begin
            s_det_detected <= (s_st == 3) && !s_det_bit;
            s_st <= det_next(s_st, s_det_bit);
        end
    end

    // Reference model: this is a list of every bit the detector has seen since it was last
    // cleared. A match is a 0110 window that does not overlap the end of the previous match.
    bit hist[$];
    int last_end;
    function automatic int ref_word(input logic [7:0] w);
        int m, n;
        m = 0;
        if (ISO != 0) begin hist.delete(); last_end = 0; end
        for (int i = 7; i >= 0; i--) begin
            hist.push_back(w[i]);
            n = hist.size();
            if (n - last_end >= 4 && hist[n-4] == 1'b0 && hist[n-3] == 1'b1 &&
                hist[n-2] == 1'b1 && hist[n-1] == 1'b0) begin
                m++;
                last_end = n;
            end
        end
        return m;
    endfunction

    int checks = 0;
    int errors = 0;
    int exp_total = 0;
    int sat_m_seen, sat_t_seen, sat_v_seen;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // This task starts with the DUT in IDLE, at a point 1 time unit after a clock edge.
    // Cycle 0 is the acceptance cycle.
    task automatic send_word(input logic [7:0] w, input int hold, input int exp_m, input string tag);
        int cyc, en_n, en_first, en_last, clr_n, clr_at;
        bit rdy_bad, hold_bad;
        logic [7:0] bits;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1; in_data = w; out_ready = 1'b0;
        en_n = 0; en_first = -1; en_last = -1; clr_n = 0; clr_at = -1; rdy_bad = 0; bits = '0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~w; cyc = 1;
        while (!out_valid && cyc < LAT + 20) begin
            if (det_en) begin
                en_n++; bits = {bits[6:0], det_bit};
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
            end
            if (det_clear) begin clr_n++; clr_at = cyc; end
            if (in_ready || !busy) rdy_bad = 1;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_det_en_count"}, en_n, DW);
        chk({tag, "_det_en_span"}, en_last - en_first + 1, DW);
        chk({tag, "_det_en_first"}, en_first, 1 + ISO);
        chk({tag, "_det_bits"}, bits, w);
        chk({tag, "_det_clear_cnt"}, clr_n, ISO);
        chk({tag, "_det_clear_at"}, clr_at, (ISO != 0) ? 1 : -1);
        chk({tag, "_busy_while_scan"}, rdy_bad, 0);
        chk({tag, "_out_matches"}, out_matches, exp_m);
        exp_total += exp_m;
        chk({tag, "_total"}, total_matches, exp_total);
        sat_m_seen = s_out_matches; sat_t_seen = s_total; sat_v_seen = s_out_valid;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_data = 8'h66;
            @(posedge clk); #1;
            if (!out_valid || out_matches !== 4'(exp_m) || in_ready) hold_bad = 1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, hold_bad, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, out_valid, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] w;
        int         hold;
        int         exp_m;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit seen;
        int m;
        logic [7:0] rw;

        tbl[0] = '{8'h36, 0, 1};
        tbl[1] = '{8'h66, 0, 2};
        tbl[2] = '{8'h01, 0, 0};
        tbl[3] = '{8'h80, 0, (ISO != 0) ? 0 : 1};
        tbl[4] = '{8'h36, 20, 1};
        tbl[5] = '{8'h00, 1, 0};
        tbl[6] = '{8'hFF, 0, 0};
        tbl[7] = '{8'h6F, 2, 1};
        tbl[8] = '{8'h03, 0, 0};
        tbl[9] = '{8'h00, 0, (ISO != 0) ? 0 : 1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_en = 1'b0;
        last_end = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_det_en", det_en, 0);
        chk("rst_det_bit", det_bit, 0);
        chk("rst_det_clear", det_clear, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_matches", out_matches, 0);
        chk("rst_total", total_matches, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send_word(tbl[i].w, tbl[i].hold, tbl[i].exp_m, $sformatf("vec%0d", i));
            void'(ref_word(tbl[i].w));
        end

        // Reset asserted in the 4th SHIFT cycle of 0x66. The partial word must be lost.
        in_valid = 1'b1; in_data = 8'h66;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3 + ISO) begin @(posedge clk); #1; end
        chk("midrst_in_shift", det_en, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_total", total_matches, 0);
        chk("midrst_out_matches", out_matches, 0);
        chk("midrst_det_en", det_en, 0);
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_result", seen, 0);
        hist.delete(); last_end = 0; exp_total = 0;

        // Saturation: the 2-bit total must stop at 3.
        reset = 1'b1; sat_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hist.delete(); last_end = 0; exp_total = 0;
        send_word(8'h66, 0, 2, "sat1");
        void'(ref_word(8'h66));
        chk("sat1_valid", sat_v_seen, 1);
        chk("sat1_matches", sat_m_seen, 2);
        chk("sat1_total", sat_t_seen, 2);
        send_word(8'h66, 2, 2, "sat2");
        void'(ref_word(8'h66));
        chk("sat2_matches", sat_m_seen, 2);
        chk("sat2_total", sat_t_seen, 3);

        // Randomized words are checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            rw = 8'($urandom_range(0, 255));
            if (i % 4 == 0) rw = 8'h66;
            m = ref_word(rw);
            send_word(rw, int'($urandom_range(0, 3)), m, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        chk("sat_final_total", s_total, 3);
        chk("sat_final_idle", {s_busy, s_in_ready}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
